// File: rtl/pic_hw_return_stack.sv
// Hardware return-address stack for the midrange core.
// Holds return PCs for CALL/RETURN/RETFIE and interrupt entry, with a
// configurable depth, entry width and overflow policy (circular or saturating).
// Also reports occupancy, keeps sticky overflow/underflow flags and
// supports replacing the top entry.
module pic_hw_return_stack #(
    parameter int ADDR_W    = 13,
    parameter int DEPTH     = 8,
    parameter int WRAP_MODE = 1,
    parameter int CNT_W     = $clog2(DEPTH + 1)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    input  logic              clear_flags,
    output logic [ADDR_W-1:0] top,
    output logic [CNT_W-1:0]  level,
    output logic              empty,
    output logic              full,
    output logic              overflow,
    output logic              underflow
);

    localparam int                PTR_W    = $clog2(DEPTH);
    localparam logic [PTR_W-1:0]  LAST_IDX = PTR_W'(DEPTH - 1);
    localparam logic [CNT_W-1:0]  FULL_LVL = CNT_W'(DEPTH);

    logic [ADDR_W-1:0] mem [DEPTH];
    logic [PTR_W-1:0]  wp;
    logic [PTR_W-1:0]  wp_inc;
    logic [PTR_W-1:0]  wp_dec;

    logic              is_empty;
    logic              is_full;
    logic              mem_we;
    logic [PTR_W-1:0]  mem_idx;
    logic [PTR_W-1:0]  wp_next;
    logic [CNT_W-1:0]  level_next;
    logic              set_ovf;
    logic              set_udf;

    // Pointer neighbours wrap explicitly so non-power-of-two depths work.
    always_comb begin
        wp_inc = (wp == LAST_IDX) ? '0 : wp + 1'b1;
        wp_dec = (wp == '0) ? LAST_IDX : wp - 1'b1;
    end

    assign is_empty = (level == '0);
    assign is_full  = (level == FULL_LVL);

    // Decode push/pop/replace into a storage write, pointer/level updates and flag sets.
    always_comb begin
        mem_we     = 1'b0;
        mem_idx    = wp;
        wp_next    = wp;
        level_next = level;
        set_ovf    = 1'b0;
        set_udf    = 1'b0;

        if (push && pop && !is_empty) begin
            // Replace top: overwrite the newest entry in place.
            mem_we  = 1'b1;
            mem_idx = wp_dec;
        end else if (push) begin
            // Plain push (also covers push+pop on an empty stack).
            if (!is_full) begin
                mem_we     = 1'b1;
                mem_idx    = wp;
                wp_next    = wp_inc;
                level_next = level + 1'b1;
            end else begin
                set_ovf = 1'b1;
                if (WRAP_MODE != 0) begin
                    mem_we  = 1'b1;
                    mem_idx = wp;
                    wp_next = wp_inc;
                end
            end
        end else if (pop) begin
            if (!is_empty) begin
                wp_next    = wp_dec;
                level_next = level - 1'b1;
            end else begin
                set_udf = 1'b1;
                if (WRAP_MODE != 0) begin
                    wp_next = wp_dec;
                end
            end
        end
    end

    // State register: storage, pointer, occupancy and sticky flags (set beats clear).
    always_ff @(posedge clk) begin
        if (rst) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
            wp        <= '0;
            level     <= '0;
            overflow  <= 1'b0;
            underflow <= 1'b0;
        end else begin
            if (mem_we) begin
                mem[mem_idx] <= push_data;
            end
            wp    <= wp_next;
            level <= level_next;

            if (set_ovf) begin
                overflow <= 1'b1;
            end else if (clear_flags) begin
                overflow <= 1'b0;
            end

            if (set_udf) begin
                underflow <= 1'b1;
            end else if (clear_flags) begin
                underflow <= 1'b0;
            end
        end
    end

    assign top   = mem[wp_dec];
    assign empty = is_empty;
    assign full  = is_full;

endmodule

// File: tb/tb_pic_hw_return_stack.sv
// Directed self-checking bench for pic_hw_return_stack.
// Instance "wr" is the default circular 8-deep stack; instance "sat" is a
// saturating 5-deep stack.
module tb_pic_hw_return_stack;

    logic clk;
    logic rst;

    // Circular instance (DEPTH=8, WRAP_MODE=1)
    logic        wr_push, wr_pop, wr_clr;
    logic [12:0] wr_data;
    logic [12:0] wr_top;
    logic [3:0]  wr_level;
    logic        wr_empty, wr_full, wr_ovf, wr_udf;

    // Saturating instance (DEPTH=5, WRAP_MODE=0)
    logic        sat_push, sat_pop, sat_clr;
    logic [12:0] sat_data;
    logic [12:0] sat_top;
    logic [2:0]  sat_level;
    logic        sat_empty, sat_full, sat_ovf, sat_udf;

    int checks = 0;
    int errors = 0;

    pic_hw_return_stack #(.ADDR_W(13), .DEPTH(8), .WRAP_MODE(1)) dut_wr (
        .clk(clk), .rst(rst), .push(wr_push), .pop(wr_pop), .push_data(wr_data),
        .clear_flags(wr_clr), .top(wr_top), .level(wr_level), .empty(wr_empty),
        .full(wr_full), .overflow(wr_ovf), .underflow(wr_udf)
    );

    pic_hw_return_stack #(.ADDR_W(13), .DEPTH(5), .WRAP_MODE(0)) dut_sat (
        .clk(clk), .rst(rst), .push(sat_push), .pop(sat_pop), .push_data(sat_data),
        .clear_flags(sat_clr), .top(sat_top), .level(sat_level), .empty(sat_empty),
        .full(sat_full), .overflow(sat_ovf), .underflow(sat_udf)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One clock of stimulus on the circular instance; outputs sampled 1ns after the edge.
    task automatic applyStimulus(input logic p, input logic q, input logic [12:0] d, input logic c);
        wr_push = p; wr_pop = q; wr_data = d; wr_clr = c;
        @(posedge clk);
        #1;
        wr_push = 1'b0; wr_pop = 1'b0; wr_clr = 1'b0;
    endtask

    // One clock of stimulus on the saturating instance.
    task automatic applyStimulusSat(input logic p, input logic q, input logic [12:0] d);
        sat_push = p; sat_pop = q; sat_data = d; sat_clr = 1'b0;
        @(posedge clk);
        #1;
        sat_push = 1'b0; sat_pop = 1'b0;
    endtask

    task automatic doReset();
        rst = 1'b1;
        @(posedge clk);
        @(posedge clk);
        #1;
        rst = 1'b0;
    endtask

    initial begin
        rst = 1'b0;
        wr_push = 0; wr_pop = 0; wr_clr = 0; wr_data = '0;
        sat_push = 0; sat_pop = 0; sat_clr = 0; sat_data = '0;

        // 1. reset then idle
        doReset();
        @(posedge clk); #1;
        checkOutput("rst_top",   32'(wr_top),   32'h0);
        checkOutput("rst_level", 32'(wr_level), 32'd0);
        checkOutput("rst_empty", 32'(wr_empty), 32'd1);
        checkOutput("rst_full",  32'(wr_full),  32'd0);
        checkOutput("rst_ovf",   32'(wr_ovf),   32'd0);
        checkOutput("rst_udf",   32'(wr_udf),   32'd0);

        // 2. fill with 0x100..0x107 then drain
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b1, 1'b0, 13'(32'h100 + i), 1'b0);
            checkOutput($sformatf("fill_level%0d", i), 32'(wr_level), 32'(i + 1));
            checkOutput($sformatf("fill_top%0d", i),   32'(wr_top),   32'h100 + i);
        end
        checkOutput("fill_full", 32'(wr_full), 32'd1);
        for (int i = 0; i < 8; i++) begin
            applyStimulus(1'b0, 1'b1, 13'h0, 1'b0);
            checkOutput($sformatf("drain_level%0d", i), 32'(wr_level), 32'(7 - i));
            if (i < 7) checkOutput($sformatf("drain_top%0d", i), 32'(wr_top), 32'h106 - i);
        end
        checkOutput("drain_empty", 32'(wr_empty), 32'd1);
        checkOutput("drain_ovf",   32'(wr_ovf),   32'd0);
        checkOutput("drain_udf",   32'(wr_udf),   32'd0);

        // 3. circular overflow and underflow
        doReset();
        for (int i = 1; i <= 9; i++) applyStimulus(1'b1, 1'b0, 13'(i), 1'b0);
        checkOutput("wrap_ovf",   32'(wr_ovf),   32'd1);
        checkOutput("wrap_level", 32'(wr_level), 32'd8);
        checkOutput("wrap_top",   32'(wr_top),   32'h9);
        for (int i = 0; i < 7; i++) begin
            applyStimulus(1'b0, 1'b1, 13'h0, 1'b0);
            checkOutput($sformatf("wrap_pop_top%0d", i), 32'(wr_top), 32'(8 - i));
        end
        applyStimulus(1'b0, 1'b1, 13'h0, 1'b0);
        checkOutput("wrap_pop8_level", 32'(wr_level), 32'd0);
        checkOutput("wrap_pop8_top",   32'(wr_top),   32'h9);
        checkOutput("wrap_pop8_udf",   32'(wr_udf),   32'd0);
        applyStimulus(1'b0, 1'b1, 13'h0, 1'b0);
        checkOutput("wrap_pop9_udf",   32'(wr_udf),   32'd1);
        checkOutput("wrap_pop9_level", 32'(wr_level), 32'd0);

        // 4. saturating, depth 5
        doReset();
        for (int i = 1; i <= 6; i++) applyStimulusSat(1'b1, 1'b0, 13'(i));
        checkOutput("sat_ovf",   32'(sat_ovf),   32'd1);
        checkOutput("sat_top",   32'(sat_top),   32'd5);
        checkOutput("sat_level", 32'(sat_level), 32'd5);
        checkOutput("sat_full",  32'(sat_full),  32'd1);
        for (int i = 0; i < 5; i++) applyStimulusSat(1'b0, 1'b1, 13'h0);
        checkOutput("sat_drain_udf", 32'(sat_udf), 32'd0);
        applyStimulusSat(1'b0, 1'b1, 13'h0);
        checkOutput("sat_udf",       32'(sat_udf),   32'd1);
        checkOutput("sat_udf_level", 32'(sat_level), 32'd0);
        checkOutput("sat_udf_empty", 32'(sat_empty), 32'd1);
        applyStimulusSat(1'b1, 1'b0, 13'h77);
        checkOutput("sat_after_top",   32'(sat_top),   32'h77);
        checkOutput("sat_after_level", 32'(sat_level), 32'd1);

        // 5. replace top
        doReset();
        applyStimulus(1'b1, 1'b0, 13'h0AAA, 1'b0);
        applyStimulus(1'b1, 1'b1, 13'h0555, 1'b0);
        checkOutput("repl_level", 32'(wr_level), 32'd1);
        checkOutput("repl_top",   32'(wr_top),   32'h555);
        applyStimulus(1'b0, 1'b1, 13'h0, 1'b0);
        checkOutput("repl_pop_empty", 32'(wr_empty), 32'd1);
        applyStimulus(1'b1, 1'b1, 13'h0123, 1'b0);
        checkOutput("repl_empty_level", 32'(wr_level), 32'd1);
        checkOutput("repl_empty_top",   32'(wr_top),   32'h123);
        checkOutput("repl_empty_udf",   32'(wr_udf),   32'd0);

        // 6. set beats clear, then clear, then reset mid-push
        doReset();
        for (int i = 0; i < 8; i++) applyStimulus(1'b1, 1'b0, 13'(32'h20 + i), 1'b0);
        checkOutput("pre_ovf", 32'(wr_ovf), 32'd0);
        applyStimulus(1'b1, 1'b0, 13'h1FF, 1'b1);
        checkOutput("set_wins_ovf", 32'(wr_ovf), 32'd1);
        applyStimulus(1'b0, 1'b0, 13'h0, 1'b1);
        checkOutput("clear_ovf", 32'(wr_ovf), 32'd0);

        doReset();
        for (int i = 0; i < 3; i++) applyStimulus(1'b1, 1'b0, 13'(32'h300 + i), 1'b0);
        checkOutput("pre_rst_level", 32'(wr_level), 32'd3);
        wr_push = 1'b1; wr_data = 13'h0FFF; rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; wr_push = 1'b0;
        checkOutput("midrst_level", 32'(wr_level), 32'd0);
        checkOutput("midrst_top",   32'(wr_top),   32'h0);
        checkOutput("midrst_empty", 32'(wr_empty), 32'd1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
